spi_master_ctrl: RTL and testbench

- Command-level SPI master that sits directly upstream of the SPI slave/single-port-RAM subsystem and drives its SS_n and MOSI pins on the shared system clock.
- Accepts one RAM command per handshake: write address, write data, read address or read data.
- Serialises each command into a slave frame.
- For read-data commands, captures the 8-bit MISO response and returns it on a one-cycle valid strobe.

---
 rtl/spi_master_ctrl.sv | 122 ++++++++++++
 tb/tb_spi_master_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// Command-level SPI master: serialises RAM commands into slave frames on SS_n/MOSI
// and captures the 8-bit MISO response of read-data commands.
module spi_master_ctrl #(
   parameter int unsigned TURNAROUND = 2,
   parameter int unsigned IDLE_GAP   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_type,
   input  logic [7:0] cmd_data,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   typedef enum logic [2:0] {IDLE, CTRL, SHIFT, TURN, RECV, GAP} state_t;

   localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
   localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

   state_t     state;
   logic [9:0] frame;
   logic [3:0] cnt;
   logic       is_read;
   logic [7:0] rx_sr;

   assign busy = ~cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         frame     <= '0;
         cnt       <= '0;
         is_read   <= 1'b0;
         rx_sr     <= '0;
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         cmd_ready <= 1'b1;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  frame     <= {cmd_type, cmd_data};
                  is_read   <= (cmd_type == 2'b11);
                  SS_n      <= 1'b0;
                  MOSI      <= cmd_type[1];
                  cmd_ready <= 1'b0;
                  state     <= CTRL;
               end
            end
            CTRL: begin
               MOSI  <= frame[9];
               frame <= {frame[8:0], 1'b0};
               cnt   <= '0;
               state <= SHIFT;
            end
            // frame is consumed from the top, so frame[9] is always the next bit out
            SHIFT: begin
               if (cnt == 4'd9) begin
                  MOSI <= 1'b0;
                  cnt  <= '0;
                  if (is_read) begin
                     state <= TURN;
                  end else begin
                     SS_n  <= 1'b1;
                     state <= GAP;
                  end
               end else begin
                  MOSI  <= frame[9];
                  frame <= {frame[8:0], 1'b0};
                  cnt   <= cnt + 4'd1;
               end
            end
            TURN: begin
               if (cnt == TURN_LAST) begin
                  cnt   <= '0;
                  state <= RECV;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            RECV: begin
               rx_sr <= {rx_sr[6:0], MISO};
               if (cnt == 4'd7) begin
                  rd_data  <= {rx_sr[6:0], MISO};
                  rd_valid <= 1'b1;
                  SS_n     <= 1'b1;
                  cnt      <= '0;
                  state    <= GAP;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt       <= '0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: begin
               SS_n      <= 1'b1;
               MOSI      <= 1'b0;
               cnt       <= '0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: two configurations, a MISO slave model and
// a monitor that checks each frame against the command that was queued for it.
module tb_spi_master_ctrl;

   localparam int TA0 = 2, IG0 = 1, TA1 = 4, IG1 = 3;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n [2];
   logic       cmd_valid [2];
   logic       cmd_ready [2];
   logic [1:0] cmd_type [2];
   logic [7:0] cmd_data [2];
   logic       rd_valid [2];
   logic [7:0] rd_data [2];
   logic       busy [2];
   logic       SS_n [2];
   logic       MOSI [2];
   logic       MISO [2];

   spi_master_ctrl #(.TURNAROUND(TA0), .IDLE_GAP(IG0)) dut0 (
      .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_type(cmd_type[0]), .cmd_data(cmd_data[0]), .rd_valid(rd_valid[0]),
      .rd_data(rd_data[0]), .busy(busy[0]), .SS_n(SS_n[0]), .MOSI(MOSI[0]), .MISO(MISO[0]));

   spi_master_ctrl #(.TURNAROUND(TA1), .IDLE_GAP(IG1)) dut1 (
      .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_type(cmd_type[1]), .cmd_data(cmd_data[1]), .rd_valid(rd_valid[1]),
      .rd_data(rd_data[1]), .busy(busy[1]), .SS_n(SS_n[1]), .MOSI(MOSI[1]), .MISO(MISO[1]));

   typedef struct packed {
      logic [1:0] t;
      logic [7:0] d;
      logic [7:0] rb;
   } cmd_s;

   cmd_s       exp_q [2][$];
   logic [7:0] sbyte_q [2][$];

   int checks = 0;
   int errors = 0;

   function automatic int ta_of(int d);
      return (d == 0) ? TA0 : TA1;
   endfunction

   function automatic int ig_of(int d);
      return (d == 0) ? IG0 : IG1;
   endfunction

   function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, d, $time, act, exp);
      end
   endfunction

   // Slave model: decodes the command type from MOSI and returns the queued byte
   // MSB first, starting TURNAROUND cycles after the last MOSI bit.
   int         sidx [2];
   bit         s_rd [2];
   logic       s_t1 [2];
   logic [7:0] s_byte [2];
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n[d] || SS_n[d]) begin
            sidx[d] = 0;
            s_rd[d] = 1'b0;
            MISO[d] = 1'b1;
         end else begin
            int w;
            if (sidx[d] == 1) s_t1[d] = MOSI[d];
            if (sidx[d] == 2 && s_t1[d] && MOSI[d]) begin
               s_rd[d]   = 1'b1;
               s_byte[d] = (sbyte_q[d].size() > 0) ? sbyte_q[d].pop_front() : 8'h00;
            end
            w = sidx[d] - (11 + ta_of(d));
            if (s_rd[d] && w >= 0 && w < 8) MISO[d] = s_byte[d][7 - w];
            else                            MISO[d] = 1'($urandom);
            sidx[d]++;
         end
      end
   end

   // Monitor: frame capture, scoreboard compare, gap and rd_valid/rd_data checks.
   bit          in_frame [2];
   bit          in_gap [2];
   bit          acc_pend [2];
   int          flen [2];
   int          gap_cnt [2];
   logic [31:0] bits [2];
   logic [7:0]  last_rd [2];
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n[d]) begin
            chk("reset_outputs", d,
                32'({SS_n[d], MOSI[d], rd_valid[d], cmd_ready[d], busy[d], rd_data[d]}),
                32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00}));
            exp_q[d].delete();
            in_frame[d] = 1'b0;
            in_gap[d]   = 1'b0;
            acc_pend[d] = 1'b0;
            last_rd[d]  = 8'h00;
         end else begin
            bit rv_exp;
            rv_exp = 1'b0;
            if (acc_pend[d])
               chk("accept_next_edge", d, 32'({SS_n[d], cmd_ready[d], busy[d]}), 32'(3'b001));
            if (SS_n[d] == 1'b0) begin
               if (!in_frame[d]) begin
                  in_frame[d] = 1'b1;
                  in_gap[d]   = 1'b0;
                  flen[d]     = 0;
                  bits[d]     = '0;
               end
               flen[d]++;
               bits[d] = {bits[d][30:0], MOSI[d]};
            end else if (in_frame[d]) begin
               in_frame[d] = 1'b0;
               in_gap[d]   = 1'b1;
               gap_cnt[d]  = 0;
               if (exp_q[d].size() == 0) begin
                  chk("unexpected_frame_len", d, 32'(flen[d]), 32'd0);
               end else begin
                  cmd_s e;
                  int   explen;
                  e      = exp_q[d].pop_front();
                  explen = (e.t == 2'b11) ? 19 + ta_of(d) : 11;
                  chk("frame_len", d, 32'(flen[d]), 32'(explen));
                  chk("mosi_bits", d, bits[d], 32'({e.t[1], e.t, e.d}) << (explen - 11));
                  if (e.t == 2'b11) begin
                     rv_exp     = 1'b1;
                     last_rd[d] = e.rb;
                  end
               end
            end else if (!in_gap[d]) begin
               chk("idle_ready", d, 32'({MOSI[d], cmd_ready[d], busy[d]}), 32'(3'b010));
            end
            if (in_gap[d]) begin
               if (gap_cnt[d] < ig_of(d)) begin
                  chk("gap_not_ready", d, 32'({SS_n[d], cmd_ready[d], busy[d]}), 32'(3'b101));
                  gap_cnt[d]++;
               end else begin
                  chk("ready_after_gap", d, 32'({SS_n[d], cmd_ready[d], busy[d]}), 32'(3'b110));
                  in_gap[d] = 1'b0;
               end
            end
            chk("rd_valid", d, 32'(rd_valid[d]), 32'(rv_exp));
            chk("rd_data", d, 32'(rd_data[d]), 32'(last_rd[d]));
            acc_pend[d] = cmd_valid[d] && cmd_ready[d];
         end
      end
   end

   task automatic wait_ready(input int d);
      for (int i = 0; i < 200; i++) begin
         if (cmd_ready[d]) return;
         @(posedge clk);
         #1;
      end
      $display("FAIL wait_ready_timeout dut%0d: cmd_ready stayed %0b, required 1", d, cmd_ready[d]);
      $fatal(1, "cmd_ready timeout");
   endtask

   task automatic issue(input int d, input logic [1:0] t, input logic [7:0] data,
                        input logic [7:0] rb, input bit hold);
      cmd_s e;
      e.t = t;
      e.d = data;
      e.rb = rb;
      cmd_type[d]  = t;
      cmd_data[d]  = data;
      cmd_valid[d] = 1'b1;
      exp_q[d].push_back(e);
      if (t == 2'b11) sbyte_q[d].push_back(rb);
      wait_ready(d);
      @(posedge clk);
      #1;
      if (!hold) begin
         cmd_valid[d] = 1'b0;
         cmd_type[d]  = 2'($urandom);
         cmd_data[d]  = 8'($urandom);
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n[d]     = 1'b0;
         cmd_valid[d] = 1'b0;
         cmd_type[d]  = 2'b00;
         cmd_data[d]  = 8'h00;
      end
      cmd_valid[0] = 1'b1;
      cmd_data[0]  = 8'hA5;
      repeat (3) @(posedge clk);
      #1;
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      issue(0, 2'b00, 8'hA5, 8'h00, 1'b0);
      issue(0, 2'b01, 8'h3C, 8'h00, 1'b1);
      issue(0, 2'b10, 8'hA5, 8'h00, 1'b0);
      issue(0, 2'b11, 8'h00, 8'h5A, 1'b0);

      issue(0, 2'b11, 8'h77, 8'hC3, 1'b0);
      repeat (16) @(posedge clk);
      #2;
      rst_n[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n[0] = 1'b1;
      sbyte_q[0].delete();
      issue(0, 2'b00, 8'h96, 8'h00, 1'b0);

      issue(1, 2'b11, 8'h00, 8'hFF, 1'b0);
      issue(1, 2'b11, 8'h00, 8'h00, 1'b0);
      issue(1, 2'b11, 8'h12, 8'h81, 1'b1);
      issue(1, 2'b00, 8'h5C, 8'h00, 1'b0);

      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 30; k++) begin
            issue(d, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  (k != 29) && ($urandom_range(0, 1) == 1));
         end
      end

      for (int i = 0; i < 500; i++) begin
         if (exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
             cmd_ready[0] && cmd_ready[1] && !in_gap[0] && !in_gap[1]) break;
         @(posedge clk);
      end
      if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
         $display("FAIL drain_timeout: pending %0d/%0d frames, required 0",
                  exp_q[0].size(), exp_q[1].size());
         $fatal(1, "drain timeout");
      end
      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
